// File: rtl/pool_pkg.sv
// Shared definitions for the streaming pooler: mode encoding, a constant
// clog2 and the derived widths used by stream_pooler and pool_reduce.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Ceiling log2 usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Number of pooled results per row and per column.
  function automatic int out_dim(input int m, input int p);
    return m / p;
  endfunction

  // Accumulator width: room for the sum of P*P unsigned N-bit samples.
  function automatic int acc_width(input int n, input int p);
    return n + 2 * clog2(p);
  endfunction

endpackage

// File: rtl/pool_reduce.sv
// Combinational window combine: folds one sample into a partial window
// result. A window's first sample replaces the stale accumulator contents.
module pool_reduce
  import pool_pkg::*;
#(
  parameter int N     = 16,
  parameter int ACC_W = 18
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [N-1:0]     sample,
  input  logic             mode,
  input  logic             first,
  output logic [ACC_W-1:0] next_acc
);

  logic [ACC_W-1:0] sample_ext;

  assign sample_ext = ACC_W'(sample);

  // Next accumulator value: load, running max or running sum.
  always_comb begin
    // NOTE: next_acc gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    next_acc = sample_ext;
    if (!first) begin
      if (mode == POOL_AVG) begin
        next_acc = acc + sample_ext;
      end else if (acc > sample_ext) begin
        next_acc = acc;
      end
    end
  end

endmodule

// File: rtl/stream_pooler.sv
// Streaming 2-D max/average pooler. Takes an M x M map in raster order and
// emits (M/P) x (M/P) results in raster order, holding only one row of
// partial window accumulators. Optional macro POOL_ROUND_EN makes average
// mode round half up (with saturation) instead of truncating.
module stream_pooler
  import pool_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 8,
  parameter int P = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy
);

  localparam int LOG_P   = clog2(P);
  localparam int SHIFT   = 2 * LOG_P;
  localparam int ACC_W   = acc_width(N, P);
  localparam int OUT_DIM = out_dim(M, P);
  localparam int CNT_W   = (clog2(M) > 0) ? clog2(M) : 1;
  localparam int OC_W    = (clog2(OUT_DIM) > 0) ? clog2(OUT_DIM) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(M - 1);

  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic             mode_q;
  logic [ACC_W-1:0] acc [OUT_DIM];

  logic             in_fire;
  logic             out_fire;
  logic             frame_start;
  logic             frame_end;
  logic             win_first;
  logic             win_done;
  logic             cur_mode;
  logic [OC_W-1:0]  oc;
  logic [ACC_W-1:0] acc_cur;
  logic [ACC_W-1:0] acc_next;
  logic [N-1:0]     avg_val;
  logic [N-1:0]     result;

  // A held, untaken result is the only thing that stalls the input.
  assign in_ready = !(out_valid && !out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign frame_start = (row == '0) && (col == '0);
  assign frame_end   = (row == LAST_IDX) && (col == LAST_IDX);
  assign win_first   = (row[LOG_P-1:0] == '0) && (col[LOG_P-1:0] == '0);
  assign win_done    = (&row[LOG_P-1:0]) && (&col[LOG_P-1:0]);

  // Pixel (0,0) uses the live mode input; the rest of the frame the latched one.
  assign cur_mode = frame_start ? mode : mode_q;
  assign oc       = OC_W'(col >> LOG_P);
  assign acc_cur  = acc[oc];

  pool_reduce #(
    .N    (N),
    .ACC_W(ACC_W)
  ) u_reduce (
    .acc     (acc_cur),
    .sample  (in_data),
    .mode    (cur_mode),
    .first   (win_first),
    .next_acc(acc_next)
  );

`ifdef POOL_ROUND_EN
  // Half an LSB of the scaled result, added before the shift.
  localparam logic [ACC_W:0] HALF = {{(ACC_W + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

  logic [ACC_W:0]       rounded;
  logic [ACC_W-SHIFT:0] scaled;

  assign rounded = {1'b0, acc_next} + HALF;
  assign scaled  = rounded[ACC_W:SHIFT];
  assign avg_val = scaled[N] ? '1 : scaled[N-1:0];
`else
  assign avg_val = acc_next[ACC_W-1:SHIFT];
`endif

  assign result = (cur_mode == POOL_AVG) ? avg_val : acc_next[N-1:0];

  // Raster counters, frame mode latch, busy flag and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= POOL_MAX;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (in_fire) begin
        if (frame_start) begin
          mode_q <= mode;
        end
        if (col == LAST_IDX) begin
          col <= '0;
          row <= (row == LAST_IDX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        // NOTE: the last non-blocking assignment in a block wins, so a new
        // result here overrides the clear above when both happen in one cycle.
        if (win_done) begin
          out_valid <= 1'b1;
          out_data  <= result;
          out_last  <= frame_end;
        end
      end
      if (in_fire && frame_start) begin
        busy <= 1'b1;
      end else if (out_fire && out_last) begin
        busy <= 1'b0;
      end
    end
  end

  // One partial window per output column, updated on every accepted pixel.
  // NOTE: the accumulator array is deliberately not reset; each window's first
  // pixel overwrites its entry, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      acc[oc] <= acc_next;
    end
  end

endmodule
